p4_router_ing_sched: RTL and testbench

- Packet-level weighted round-robin scheduler for the P4 router ingress buffer.
- Each physical ingress port's buffer region raises a request when it holds at least one complete packet.
- The scheduler grants exactly one port at a time. The grant is held until the buffer read side transfers that packet's tlast beat onto the converged ingress bus toward VNP4.
- A watchdog releases a hung grant and reports the fault.

---
 rtl/p4_router_pkg.sv | 13 +
 rtl/p4_router_rr_pick.sv | 33 +++
 rtl/p4_router_ing_sched.sv | 131 +++++++++++++
 tb/tb_p4_router_ing_sched.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/p4_router_pkg.sv
// Shared types and defaults for the P4 router ingress/egress schedulers.
package p4_router_pkg;

    typedef enum logic {ING_SCHED_IDLE, ING_SCHED_GRANT} ing_sched_state_t;

    localparam int ING_SCHED_DEFAULT_MAX_PKT_CYCLES = 4096;

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/p4_router_rr_pick.sv
// Combinational rotating priority encoder: first set request at or after ptr, with wrap.
module p4_router_rr_pick
    import p4_router_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int IDX_WIDTH = idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic                 found,
    output logic [IDX_WIDTH-1:0] idx
);

    int w_dist;
    int w_best;

    // Smallest rotated distance from ptr wins.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        w_dist = 0;
        w_best = NUM_PORTS;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_dist = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + NUM_PORTS - int'(ptr));
            if (req[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                found  = 1'b1;
                idx    = IDX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/p4_router_ing_sched.sv
// Packet-level weighted round-robin scheduler for the ingress buffer, with a
// grant watchdog. One grant at a time, held until the packet's tlast beat.
module p4_router_ing_sched
    import p4_router_pkg::*;
#(
    parameter int NUM_PORTS      = 4,
    parameter int WEIGHT_WIDTH   = 4,
    parameter int MAX_PKT_CYCLES = ING_SCHED_DEFAULT_MAX_PKT_CYCLES,
    parameter int CNT_WIDTH      = 32,
    parameter int IDX_WIDTH      = idx_width(NUM_PORTS)
) (
    input  logic                              clk,
    input  logic                              sreset,
    input  logic [NUM_PORTS-1:0]              port_pkt_rdy,
    input  logic [NUM_PORTS-1:0]              port_enable,
    input  logic [NUM_PORTS*WEIGHT_WIDTH-1:0] port_weight,
    input  logic                              rd_valid,
    input  logic                              rd_ready,
    input  logic                              rd_last,
    output logic                              grant_valid,
    output logic [IDX_WIDTH-1:0]              grant_idx,
    output logic [NUM_PORTS-1:0]              grant_onehot,
    output logic                              timeout_err,
    input  logic                              err_clear,
    output logic [CNT_WIDTH-1:0]              pkt_cnt,
    output logic [CNT_WIDTH-1:0]              timeout_cnt
);

    localparam int WD_W = $clog2(MAX_PKT_CYCLES);

    ing_sched_state_t                           r_state;
    logic [IDX_WIDTH-1:0]                       r_rr_ptr;
    logic [WD_W-1:0]                            r_wdog;
    logic [NUM_PORTS-1:0][WEIGHT_WIDTH-1:0]     r_credit;

    logic [NUM_PORTS-1:0]                       w_elig;
    logic [NUM_PORTS-1:0][WEIGHT_WIDTH-1:0]     w_reload;
    logic                                       w_found;
    logic [IDX_WIDTH-1:0]                       w_pick;
    logic                                       w_last;
    logic                                       w_wd_hit;
    logic [WEIGHT_WIDTH-1:0]                    w_cred_dec;
    logic [IDX_WIDTH-1:0]                       w_next_ptr;

    assign w_elig     = port_pkt_rdy & port_enable;
    assign w_last     = rd_valid & rd_ready & rd_last;
    assign w_wd_hit   = (r_wdog == WD_W'(MAX_PKT_CYCLES - 1));
    assign w_cred_dec = r_credit[grant_idx] - WEIGHT_WIDTH'(1);
    assign w_next_ptr = (grant_idx == IDX_WIDTH'(NUM_PORTS - 1)) ? '0
                                                                 : grant_idx + IDX_WIDTH'(1);

    // A zero weight still grants one packet per turn.
    always_comb begin
        w_reload = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_reload[i] = (port_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] == '0)
                        ? WEIGHT_WIDTH'(1) : port_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        end
    end

    p4_router_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick (
        .req   (w_elig),
        .ptr   (r_rr_ptr),
        .found (w_found),
        .idx   (w_pick)
    );

    always_ff @(posedge clk) begin
        if (sreset) begin
            r_state      <= ING_SCHED_IDLE;
            r_rr_ptr     <= '0;
            r_wdog       <= '0;
            r_credit     <= w_reload;
            grant_valid  <= 1'b0;
            grant_idx    <= '0;
            grant_onehot <= '0;
            timeout_err  <= 1'b0;
            pkt_cnt      <= '0;
            timeout_cnt  <= '0;
        end else begin
            case (r_state)
                ING_SCHED_IDLE: begin
                    if (w_found) begin
                        r_state      <= ING_SCHED_GRANT;
                        grant_valid  <= 1'b1;
                        grant_idx    <= w_pick;
                        grant_onehot <= NUM_PORTS'(1) << w_pick;
                        r_wdog       <= '0;
                        // An idle port passed over by the pointer forfeits banked credit.
                        if (!w_elig[r_rr_ptr])
                            r_credit[r_rr_ptr] <= w_reload[r_rr_ptr];
                    end
                end
                ING_SCHED_GRANT: begin
                    r_wdog <= r_wdog + WD_W'(1);
                    if (w_last) begin
                        r_state      <= ING_SCHED_IDLE;
                        grant_valid  <= 1'b0;
                        grant_onehot <= '0;
                        pkt_cnt      <= pkt_cnt + CNT_WIDTH'(1);
                        if (w_cred_dec == '0) begin
                            r_credit[grant_idx] <= w_reload[grant_idx];
                            r_rr_ptr            <= w_next_ptr;
                        end else begin
                            r_credit[grant_idx] <= w_cred_dec;
                            r_rr_ptr            <= grant_idx;
                        end
                    end else if (w_wd_hit) begin
                        r_state             <= ING_SCHED_IDLE;
                        grant_valid         <= 1'b0;
                        grant_onehot        <= '0;
                        timeout_err         <= 1'b1;
                        r_credit[grant_idx] <= w_reload[grant_idx];
                        r_rr_ptr            <= w_next_ptr;
                        if (timeout_cnt != '1)
                            timeout_cnt <= timeout_cnt + CNT_WIDTH'(1);
                    end
                end
                default: r_state <= ING_SCHED_IDLE;
            endcase
            if (err_clear) begin
                timeout_err <= 1'b0;
                timeout_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_p4_router_ing_sched.sv
// Directed bench: expected grant order goes into a queue, a negedge monitor pops and compares.
module tb_p4_router_ing_sched;

    localparam int NP = 4, WW = 4, MAXC = 16, CW = 32, IW = 2;

    logic            clk = 1'b0;
    logic            sreset = 1'b1;
    logic [NP-1:0]   port_pkt_rdy = '0;
    logic [NP-1:0]   port_enable = '0;
    logic [NP*WW-1:0] port_weight = 16'h1111;
    logic            rd_valid = 1'b0, rd_ready = 1'b0, rd_last = 1'b0;
    logic            grant_valid;
    logic [IW-1:0]   grant_idx;
    logic [NP-1:0]   grant_onehot;
    logic            timeout_err;
    logic            err_clear = 1'b0;
    logic [CW-1:0]   pkt_cnt, timeout_cnt;

    always #5 clk = ~clk;

    p4_router_ing_sched #(
        .NUM_PORTS(NP), .WEIGHT_WIDTH(WW), .MAX_PKT_CYCLES(MAXC), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .sreset(sreset), .port_pkt_rdy(port_pkt_rdy), .port_enable(port_enable),
        .port_weight(port_weight), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
        .grant_valid(grant_valid), .grant_idx(grant_idx), .grant_onehot(grant_onehot),
        .timeout_err(timeout_err), .err_clear(err_clear), .pkt_cnt(pkt_cnt),
        .timeout_cnt(timeout_cnt)
    );

    int n_vec = 0, n_err = 0;
    int exp_q[$];
    logic prev_gv = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: grant order from scoreboard, onehot consistency every cycle.
    initial forever begin
        @(negedge clk);
        check("onehot", 32'(grant_onehot), grant_valid ? (32'd1 << grant_idx) : 32'd0);
        if (grant_valid && !prev_gv) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_grant: got idx %0d expected no grant", grant_idx);
            end else begin
                check("grant_order", 32'(grant_idx), exp_q.pop_front());
            end
        end
        prev_gv = grant_valid;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        sreset = 1'b1; rd_valid = 1'b0; rd_last = 1'b0; port_enable = '0;
        @(negedge clk); @(negedge clk);
        sreset = 1'b0;
    endtask

    task automatic wait_grant(output int waited);
        int t = 0;
        while (!grant_valid && t < 64) begin @(negedge clk); t++; end
        waited = t;
        check("grant_seen", 32'(grant_valid), 1);
    endtask

    // Serve one packet of 'beats' beats; optionally withdraw the port mid-packet.
    task automatic serve(input int beats, input int exp_idx, input bit kill, output int waited);
        wait_grant(waited);
        for (int b = 1; b <= beats; b++) begin
            if (kill && b == 2) begin
                port_enable[exp_idx] = 1'b0; port_pkt_rdy[exp_idx] = 1'b0;
            end
            check("hold_idx", 32'(grant_idx), exp_idx);
            rd_valid = 1'b1; rd_ready = 1'b1; rd_last = (b == beats);
            @(negedge clk);
        end
        rd_valid = 1'b0; rd_last = 1'b0;
        check("release_after_last", 32'(grant_valid), 0);
    endtask

    int w, cnt;
    int seq1[5] = '{0, 1, 2, 3, 0};
    int seq2[9] = '{0, 0, 0, 1, 2, 3, 0, 0, 0};

    initial begin
        // Reset state
        @(negedge clk); @(negedge clk);
        check("rst_grant_valid", 32'(grant_valid), 0);
        check("rst_grant_idx", 32'(grant_idx), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_timeout_cnt", timeout_cnt, 0);
        sreset = 1'b0;

        // Equal weights, 3-beat packets: plain rotation, one bubble between grants
        port_weight = 16'h1111; do_reset();
        port_pkt_rdy = '1; port_enable = '1;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(seq1[k]);
            serve(3, seq1[k], 1'b0, w);
            if (k > 0) check("t1_bubble", w, 1);
        end
        port_enable = '0;
        check("t1_pkt_cnt", pkt_cnt, 5);

        // Weights {3,1,1,1}
        port_weight = 16'h1113; do_reset();
        port_enable = '1;
        for (int k = 0; k < 9; k++) begin
            exp_q.push_back(seq2[k]);
            serve(2, seq2[k], 1'b0, w);
            if (k > 0) check("t2_bubble", w, 1);
        end
        port_enable = '0;
        check("t2_pkt_cnt", pkt_cnt, 9);

        // Port 1 withdrawn mid-packet: grant held, then never regranted
        port_weight = 16'h1111; do_reset();
        port_pkt_rdy = '1; port_enable = 4'b1010;
        exp_q.push_back(1); serve(4, 1, 1'b1, w);
        exp_q.push_back(3); serve(2, 3, 1'b0, w);
        check("t3_bubble", w, 1);
        exp_q.push_back(3); serve(2, 3, 1'b0, w);
        port_enable = '0;
        check("t3_pkt_cnt", pkt_cnt, 3);

        // Watchdog on port 2, next grant to port 3, then err_clear
        do_reset();
        port_pkt_rdy = '1; port_enable = 4'b1100;
        exp_q.push_back(2); exp_q.push_back(3);
        wait_grant(w);
        cnt = 0;
        while (grant_valid && cnt < 40) begin cnt++; @(negedge clk); end
        check("t4_grant_cycles", cnt, 16);
        check("t4_timeout_err", 32'(timeout_err), 1);
        check("t4_timeout_cnt", timeout_cnt, 1);
        check("t4_pkt_cnt_hold", pkt_cnt, 0);
        serve(2, 3, 1'b0, w);
        port_enable = '0;
        check("t4_next_bubble", w, 1);
        check("t4_err_sticky", 32'(timeout_err), 1);
        err_clear = 1'b1; @(negedge clk); err_clear = 1'b0;
        check("t4_err_cleared", 32'(timeout_err), 0);
        check("t4_cnt_cleared", timeout_cnt, 0);
        check("t4_pkt_cnt", pkt_cnt, 1);

        // Weight 0 on lone port 3: treated as 1, single bubble between grants
        port_weight = 16'h0111; do_reset();
        port_enable = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(3);
            serve(1, 3, 1'b0, w);
            if (k > 0) check("t5_bubble", w, 1);
        end
        port_enable = '0;
        check("t5_pkt_cnt", pkt_cnt, 3);

        // Reset in the middle of a grant
        port_weight = 16'h1111; do_reset();
        port_enable = '1;
        exp_q.push_back(0); serve(2, 0, 1'b0, w);
        exp_q.push_back(1); wait_grant(w);
        rd_valid = 1'b1; rd_ready = 1'b1; rd_last = 1'b0;
        @(negedge clk);
        check("t6_mid_grant_idx", 32'(grant_idx), 1);
        check("t6_pkt_cnt_pre", pkt_cnt, 1);
        sreset = 1'b1; rd_valid = 1'b0;
        @(negedge clk);
        check("t6_rst_grant_valid", 32'(grant_valid), 0);
        check("t6_rst_pkt_cnt", pkt_cnt, 0);
        check("t6_rst_timeout_cnt", timeout_cnt, 0);
        port_enable = 4'b1001;
        @(negedge clk);
        sreset = 1'b0;
        exp_q.push_back(0); serve(2, 0, 1'b0, w);
        port_enable = '0;
        check("t6_pkt_cnt", pkt_cnt, 1);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
